screen_sequencer: RTL

Top-level screen/state controller that drives the three mutually exclusive screen-select flags (`start_state`, `game_state`, `wait_state`) consumed by the display path. It sequences START → GAME → REVEAL → WAIT → GAME… from keyboard input, per-frame ticks and hand-completion events from the poker FSM. It also issues the one-cycle `new_match` and `new_hand` commands back to the poker FSM, so it sits between the keyboard/poker logic and the screen renderer.

---
 rtl/screen_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/screen_sequencer.sv
// Screen/state controller: START -> GAME -> REVEAL -> WAIT -> GAME ..., with new_match/new_hand commands.
// Optional SCREEN_AUTO_ADVANCE_EN: WAIT also leaves after WAIT_FRAMES frame ticks.
module screen_sequencer #(
   parameter int unsigned REVEAL_FRAMES = 180,
   parameter int unsigned WAIT_FRAMES   = 120,
   parameter logic [7:0]  START_KEY     = 8'h28,
   parameter logic [7:0]  SKIP_KEY      = 8'h2C
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] keycode,
   input  logic       frame_tick,
   input  logic       hand_done,
   input  logic       match_over,
   output logic       start_state,
   output logic       game_state,
   output logic       wait_state,
   output logic       reveal,
   output logic       new_match,
   output logic       new_hand,
   output logic [7:0] hands_played
);

   localparam int unsigned CNT_W = 16;
   localparam int unsigned HP_W  = 8;
   localparam logic [HP_W-1:0] HP_MAX = {HP_W{1'b1}};

   typedef enum logic [1:0] {
      ST_START  = 2'd0,
      ST_GAME   = 2'd1,
      ST_REVEAL = 2'd2,
      ST_WAIT   = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
   logic [7:0]         key_prev_q;
   logic [HP_W-1:0]    hands_q, hands_d;
   logic               new_match_q, new_match_d;
   logic               new_hand_q, new_hand_d;
   logic               start_q, game_q, wait_q, reveal_q;

   logic               start_press;
   logic               skip_press;
   logic               reveal_exp;
   logic               wait_exp;
   logic               count_en;

   // Edge-detected key presses: a held key fires only on its first cycle.
   assign start_press = (keycode == START_KEY) && (key_prev_q != START_KEY);
   assign skip_press  = (keycode == SKIP_KEY)  && (key_prev_q != SKIP_KEY);
   assign reveal_exp  = frame_tick && (frame_cnt_q == CNT_W'(REVEAL_FRAMES - 1));

`ifdef SCREEN_AUTO_ADVANCE_EN
   assign wait_exp = frame_tick && (frame_cnt_q == CNT_W'(WAIT_FRAMES - 1));
`else
   logic unused_wait_frames;
   assign wait_exp           = 1'b0;
   assign unused_wait_frames = (CNT_W'(WAIT_FRAMES) == '0);
`endif

   // Next-state, pulse and counter logic.
   always_comb begin
      state_d     = state_q;
      new_match_d = 1'b0;
      new_hand_d  = 1'b0;
      hands_d     = hands_q;
      frame_cnt_d = frame_cnt_q;
      count_en    = 1'b0;

      case (state_q)
         ST_START: begin
            if (start_press) begin
               state_d     = ST_GAME;
               new_match_d = 1'b1;
               new_hand_d  = 1'b1;
               hands_d     = '0;
            end
         end
         ST_GAME: begin
            if (hand_done) begin
               state_d = ST_REVEAL;
               if (hands_q != HP_MAX) begin
                  hands_d = hands_q + HP_W'(1);
               end
            end
         end
         ST_REVEAL: begin
            count_en = 1'b1;
            if (reveal_exp || skip_press) begin
               state_d = match_over ? ST_START : ST_WAIT;
            end
         end
         ST_WAIT: begin
`ifdef SCREEN_AUTO_ADVANCE_EN
            count_en = 1'b1;
`endif
            if (start_press || wait_exp) begin
               state_d    = ST_GAME;
               new_hand_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_START;
         end
      endcase

      // Every state entry restarts the frame count from zero.
      if (state_d != state_q) begin
         frame_cnt_d = '0;
      end else if (count_en && frame_tick) begin
         frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_START;
         frame_cnt_q <= '0;
         key_prev_q  <= '0;
         hands_q     <= '0;
         new_match_q <= 1'b0;
         new_hand_q  <= 1'b0;
         start_q     <= 1'b1;
         game_q      <= 1'b0;
         wait_q      <= 1'b0;
         reveal_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         key_prev_q  <= keycode;
         hands_q     <= hands_d;
         new_match_q <= new_match_d;
         new_hand_q  <= new_hand_d;
         start_q     <= (state_d == ST_START);
         game_q      <= (state_d == ST_GAME) || (state_d == ST_REVEAL);
         wait_q      <= (state_d == ST_WAIT);
         reveal_q    <= (state_d == ST_REVEAL);
      end
   end

   assign start_state  = start_q;
   assign game_state   = game_q;
   assign wait_state   = wait_q;
   assign reveal       = reveal_q;
   assign new_match    = new_match_q;
   assign new_hand     = new_hand_q;
   assign hands_played = hands_q;

endmodule
